comm_master: RTL and testbench
==============================

# comm_master

Wireless-link command master used on the host side of the quadcopter bench. It sends a 3-byte command frame (command byte, data high byte, data low byte) over an 8N1 UART line to the copter. It also receives the copter's 1-byte response on a second UART line. It sits between the bench stimulus and the flight controller's RX/TX pins.

## Interface
- Reset: one clock; reset is synchronous and active-high.
- `BAUD_DIV`, default 2604: clocks per UART bit. Must be ≥ 4.
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `cmd`, in, 8: command byte. Latched on an accepted `send_cmd`.
- `data`, in, 16: command payload. Latched on an accepted `send_cmd`.
- `send_cmd`, in, 1: single-cycle request to start a frame.
- `TX`, out, 1: serial line to the copter. Idles high.
- `RX`, in, 1: serial line from the copter. Asynchronous; idles high.
- `frm_snt`, out, 1: high once the full 3-byte frame has been transmitted.
- `resp`, out, 8: last response byte received.
- `resp_rdy`, out, 1: a new response byte is valid.

## Operation
- UART format on both directions:
  - 8 data bits, LSB first.
  - One start bit (0) and one stop bit (1); no parity.
  - Each bit lasts `BAUD_DIV` clocks.
- Transmit FSM states: IDLE, SEND_HI_PREP, SEND_LO_PREP, WAIT_LAST.
  - In IDLE, a `send_cmd` is accepted. On acceptance: latch `data[15:0]`, load `cmd` into the transmitter, clear `frm_snt`, go to SEND_HI_PREP.
  - When byte 1 completes, load `data[15:8]` and go to SEND_LO_PREP.
  - When byte 2 completes, load `data[7:0]` and go to WAIT_LAST.
  - When byte 3 completes, set `frm_snt` and return to IDLE.
- Bytes are sent back-to-back with no idle gap: the next start bit begins the cycle after the previous stop bit ends.
- `send_cmd` outside IDLE is ignored. It does not restart the frame or corrupt the latched data.
- `frm_snt` stays high until the next accepted `send_cmd`.
- Receiver:
  - `RX` passes through a 2-flop synchronizer, with the flops preset to 1.
  - A falling edge while the receiver is idle starts reception.
  - Each bit is sampled at mid-bit, i.e. `BAUD_DIV/2` clocks into the bit.
  - At the mid-point of the stop bit, the shifted byte is copied to `resp` and `resp_rdy` is set. The stop-bit value is not checked.
- `resp_rdy` clears on an accepted `send_cmd` or on the start-bit detection of the next received byte, whichever comes first.
- `resp` holds its value until the next byte completes.
- Transmit and receive are fully independent. A response may arrive while a frame is still being sent.

## Timing
- Reset values: `TX`=1, `frm_snt`=0, `resp_rdy`=0, `resp`=0x00. The FSM is in IDLE and the receiver is idle.
- `send_cmd` sampled high in IDLE at edge N: `TX` falls at edge N+1 (start bit of byte 1).
- `frm_snt` rises exactly 30·`BAUD_DIV` clocks after `TX` first falls, and `TX` is high at that point.
- `RX` start bit: sampled through the synchronizer, so 2 cycles of latency.
- `resp_rdy` rises about 9.5·`BAUD_DIV`+2 clocks after the `RX` falling edge.
- Reset mid-frame or mid-receive: everything returns to reset values on the next edge.
  - A partial transmit byte is abandoned and `TX` goes high.
  - A partial receive byte is discarded.
- Same-cycle `send_cmd` and receive completion: `resp` updates and `resp_rdy` is set, since the completion wins over the clear.

## Structure
- Shared package `comm_pkg`: transmit FSM state enum and the default `BAUD_DIV` constant.
- One sub-module, `uart_trx`.
  - Transmit port: `trmt`, `tx_data`, `tx_done`, `TX`.
  - Receive port: `RX`, `rx_data`, `rdy`.
  - Both directions use the same `BAUD_DIV` parameter.
- `comm_master` contains the frame FSM, the data latch, and the `frm_snt`/`resp_rdy` flags.

## Test plan
All scenarios run with `BAUD_DIV`=16.
- Reset check: hold `rst` for 3 cycles → `TX`=1, `frm_snt`=0, `resp_rdy`=0, `resp`=0x00.
- Frame transmit: `cmd`=0x01, `data`=0xA55A, pulse `send_cmd` → `TX` decodes as 0x01, 0xA5, 0x5A, contiguous. `frm_snt` rises at 480 clocks after the first start bit.
- Busy ignore: pulse `send_cmd` with `cmd`=0x02 while byte 2 is in flight → frame is still 0x01/0xA5/0x5A. No second frame follows.
- Response receive: drive 0xC0 on `RX` → `resp`=0xC0 and `resp_rdy`=1.
  - Then pulse `send_cmd` → `resp_rdy` drops the next cycle and `resp` stays 0xC0.
- Back-to-back responses: drive 0xC0, 0xBF, 0xBE with no gaps → `resp` steps C0→BF→BE. `resp_rdy` pulses low at each start bit.
- Reset mid-frame: assert `rst` during byte 2 → `TX`=1 the next cycle, `frm_snt`=0.
  - Then send `cmd`=0x03, `data`=0x0000 → a clean full frame follows.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared definitions for the quadcopter command master: frame FSM states
// and the default UART bit period.
package comm_pkg;

  localparam int unsigned BAUD_DIV_DEFAULT = 2604;

  typedef enum logic [1:0] {
    IDLE,
    SEND_HI_PREP,
    SEND_LO_PREP,
    WAIT_LAST
  } tx_state_e;

endpackage

// File: rtl/uart_trx.sv
// 8N1 UART transceiver: independent transmitter and receiver sharing one
// bit period. The transmitter can chain a new byte on the last clock of the
// previous stop bit so consecutive bytes leave with no idle gap.
module uart_trx
  import comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rdy
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_MID  = CW'(BAUD_DIV / 2);

  // transmitter state
  logic          tx_busy_q, tx_busy_d;
  logic          tx_q, tx_d;
  logic [8:0]    tx_sr_q, tx_sr_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [CW-1:0] tx_baud_q, tx_baud_d;
  logic          tx_bit_end;
  logic          tx_load;

  // receiver state
  logic          rx_ff1_q, rx_ff1_d;
  logic          rx_ff2_q, rx_ff2_d;
  logic          rx_prev_q, rx_prev_d;
  logic          rx_busy_q, rx_busy_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [CW-1:0] rx_baud_q, rx_baud_d;
  logic [7:0]    rx_sr_q, rx_sr_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rdy_q, rdy_d;
  logic          rx_start;

  assign tx_bit_end = tx_busy_q && (tx_baud_q == BAUD_LAST);
  assign tx_done    = tx_bit_end && (tx_bit_q == 4'd9);
  assign tx_load    = trmt && (!tx_busy_q || tx_done);
  assign TX         = tx_q;

  assign rx_start = !rx_busy_q && rx_prev_q && !rx_ff2_q;
  assign rx_data  = rx_data_q;
  assign rdy      = rdy_q;

  // Transmit next-state: start bit on load, then shift data LSB first, stop bit last.
  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_d      = tx_q;
    tx_sr_d   = tx_sr_q;
    tx_bit_d  = tx_bit_q;
    tx_baud_d = tx_baud_q;
    if (tx_load) begin
      tx_busy_d = 1'b1;
      tx_d      = 1'b0;
      tx_sr_d   = {1'b1, tx_data};
      tx_bit_d  = '0;
      tx_baud_d = '0;
    end else if (tx_busy_q) begin
      tx_baud_d = tx_baud_q + 1'b1;
      if (tx_bit_end) begin
        tx_baud_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          tx_d      = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 4'd1;
          tx_d     = tx_sr_q[0];
          tx_sr_d  = {1'b1, tx_sr_q[8:1]};
        end
      end
    end
  end

  // Receive next-state: synchronize RX, start on a falling edge, sample each bit at mid-period.
  always_comb begin
    rx_ff1_d  = RX;
    rx_ff2_d  = rx_ff1_q;
    rx_prev_d = rx_ff2_q;
    rx_busy_d = rx_busy_q;
    rx_bit_d  = rx_bit_q;
    rx_baud_d = rx_baud_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    rdy_d     = rdy_q;
    if (rx_start) begin
      rx_busy_d = 1'b1;
      rx_bit_d  = '0;
      rx_baud_d = '0;
      rdy_d     = 1'b0;
    end else if (rx_busy_q) begin
      rx_baud_d = rx_baud_q + 1'b1;
      if (rx_baud_q == BAUD_LAST) begin
        rx_baud_d = '0;
        rx_bit_d  = rx_bit_q + 4'd1;
      end
      if (rx_baud_q == BAUD_MID) begin
        if (rx_bit_q == 4'd9) begin
          rx_busy_d = 1'b0;
          rx_data_d = rx_sr_q;
          rdy_d     = 1'b1;
        end else if (rx_bit_q != 4'd0) begin
          rx_sr_d = {rx_ff2_q, rx_sr_q[7:1]};
        end
      end
    end
  end

  // State registers for both directions; the RX synchronizer presets to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy_q <= 1'b0;
      tx_q      <= 1'b1;
      tx_sr_q   <= '1;
      tx_bit_q  <= '0;
      tx_baud_q <= '0;
      rx_ff1_q  <= 1'b1;
      rx_ff2_q  <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_busy_q <= 1'b0;
      rx_bit_q  <= '0;
      rx_baud_q <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      rdy_q     <= 1'b0;
    end else begin
      tx_busy_q <= tx_busy_d;
      tx_q      <= tx_d;
      tx_sr_q   <= tx_sr_d;
      tx_bit_q  <= tx_bit_d;
      tx_baud_q <= tx_baud_d;
      rx_ff1_q  <= rx_ff1_d;
      rx_ff2_q  <= rx_ff2_d;
      rx_prev_q <= rx_prev_d;
      rx_busy_q <= rx_busy_d;
      rx_bit_q  <= rx_bit_d;
      rx_baud_q <= rx_baud_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      rdy_q     <= rdy_d;
    end
  end

endmodule

// File: rtl/comm_master.sv
// Host-side command master: sends a 3-byte frame (cmd, data hi, data lo)
// over UART and captures the 1-byte response from the copter.
module comm_master
  import comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        send_cmd,
  output logic        TX,
  input  logic        RX,
  output logic        frm_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy
);

  tx_state_e   state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic        frm_snt_q, frm_snt_d;
  logic        resp_rdy_q, resp_rdy_d;
  logic        rdy_prev_q, rdy_prev_d;
  logic [7:0]  resp_q, resp_d;

  logic        trmt;
  logic        tx_done;
  logic        rdy;
  logic        accept;
  logic        rdy_rise;
  logic [7:0]  tx_data;
  logic [7:0]  rx_data;

  uart_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .TX      (TX),
    .RX      (RX),
    .rx_data (rx_data),
    .rdy     (rdy)
  );

  assign accept   = (state_q == IDLE) && send_cmd;
  assign trmt     = (state_q == SEND_HI_PREP) || (state_q == SEND_LO_PREP);
  assign rdy_rise = rdy && !rdy_prev_q;

  assign frm_snt  = frm_snt_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

  // Byte select: cmd starts the frame; on a byte completion the next data
  // byte is offered in that same cycle so the transmitter chains it gap-free.
  always_comb begin
    tx_data = cmd_q;
    if (tx_done) begin
      tx_data = (state_q == SEND_HI_PREP) ? data_q[15:8] : data_q[7:0];
    end
  end

  // Frame FSM and flag next-state; a receive completion outranks a send clear.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    frm_snt_d  = frm_snt_q;
    resp_rdy_d = resp_rdy_q;
    resp_d     = resp_q;
    rdy_prev_d = rdy;
    unique case (state_q)
      IDLE: begin
        if (send_cmd) begin
          cmd_d     = cmd;
          data_d    = data;
          frm_snt_d = 1'b0;
          state_d   = SEND_HI_PREP;
        end
      end
      SEND_HI_PREP: if (tx_done) state_d = SEND_LO_PREP;
      SEND_LO_PREP: if (tx_done) state_d = WAIT_LAST;
      WAIT_LAST: begin
        if (tx_done) begin
          frm_snt_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept || !rdy) resp_rdy_d = 1'b0;
    if (rdy_rise) begin
      resp_rdy_d = 1'b1;
      resp_d     = rx_data;
    end
  end

  // Frame FSM, latched frame contents and host-visible flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      data_q     <= '0;
      frm_snt_q  <= 1'b0;
      resp_rdy_q <= 1'b0;
      rdy_prev_q <= 1'b0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      frm_snt_q  <= frm_snt_d;
      resp_rdy_q <= resp_rdy_d;
      rdy_prev_q <= rdy_prev_d;
      resp_q     <= resp_d;
    end
  end

endmodule

// File: tb/tb_comm_master.sv
// Directed bench for comm_master at BAUD_DIV=16: frame transmit, busy
// ignore, response receive, back-to-back responses, reset mid-frame.
module tb_comm_master;

  localparam int unsigned BD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cmd = '0;
  logic [15:0] data = '0;
  logic        send_cmd = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic        frm_snt;
  logic [7:0]  resp;
  logic        resp_rdy;

  int n_compared = 0;
  int n_mismatched = 0;

  comm_master #(.BAUD_DIV(BD)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .data     (data),
    .send_cmd (send_cmd),
    .TX       (TX),
    .RX       (RX),
    .frm_snt  (frm_snt),
    .resp     (resp),
    .resp_rdy (resp_rdy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse send_cmd, decode the 30 bit slots of TX at mid-bit and check
  // framing, bytes, frm_snt timing and that no further frame follows.
  task automatic send_frame(input logic [7:0] c, input logic [15:0] d,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input int inj);
    logic [29:0] bits;
    logic [7:0]  exp_b [3];
    int lows;
    exp_b[0] = e0;
    exp_b[1] = e1;
    exp_b[2] = e2;
    bits = '0;
    cmd = c;
    data = d;
    send_cmd = 1'b1;
    tick();
    send_cmd = 1'b0;
    check_eq("tx_idle_at_accept", 32'(TX), 1);
    check_eq("frm_snt_clear", 32'(frm_snt), 0);
    tick();
    check_eq("tx_start_edge", 32'(TX), 0);
    for (int k = 1; k <= 480; k++) begin
      tick();
      if (k == inj) begin
        cmd = 8'h02;
        data = 16'hFFFF;
        send_cmd = 1'b1;
      end else begin
        send_cmd = 1'b0;
      end
      if (k >= 8 && ((k - 8) % 16) == 0) bits[(k - 8) / 16] = TX;
      if (k == 479) check_eq("frm_snt_early", 32'(frm_snt), 0);
    end
    check_eq("frm_snt_rise", 32'(frm_snt), 1);
    check_eq("tx_high_at_done", 32'(TX), 1);
    for (int b = 0; b < 3; b++) begin
      check_eq($sformatf("framing_b%0d", b), 32'({bits[10*b], bits[10*b+9]}), 32'h1);
      check_eq($sformatf("byte_b%0d", b), 32'(bits[10*b+1 +: 8]), 32'(exp_b[b]));
    end
    lows = 0;
    repeat (200) begin
      tick();
      if (!TX) lows++;
    end
    check_eq("no_extra_frame", 32'(lows), 0);
  endtask

  // Drive one 8N1 byte on RX, checking the flag drops at the start bit
  // while resp holds, then that the new byte is reported.
  task automatic rx_byte(input logic [7:0] b, input logic [7:0] prev);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      for (int k = 0; k < int'(BD); k++) begin
        tick();
        if (i == 0 && k == 7) begin
          check_eq("rdy_low_at_start", 32'(resp_rdy), 0);
          check_eq("resp_hold", 32'(resp), 32'(prev));
        end
      end
    end
    check_eq("resp_rdy_set", 32'(resp_rdy), 1);
    check_eq("resp_value", 32'(resp), 32'(b));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    // reset state
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_tx", 32'(TX), 1);
    check_eq("rst_frm_snt", 32'(frm_snt), 0);
    check_eq("rst_resp_rdy", 32'(resp_rdy), 0);
    check_eq("rst_resp", 32'(resp), 0);
    rst = 1'b0;
    tick();

    // plain frame, then a frame with a send_cmd during byte 2
    send_frame(8'h01, 16'hA55A, 8'h01, 8'hA5, 8'h5A, 0);
    send_frame(8'h01, 16'hA55A, 8'h01, 8'hA5, 8'h5A, 200);

    // single response, then send_cmd clears the flag but keeps the byte
    rx_byte(8'hC0, 8'h00);
    cmd = 8'h05;
    data = 16'h1234;
    send_cmd = 1'b1;
    tick();
    send_cmd = 1'b0;
    check_eq("rdy_clr_on_send", 32'(resp_rdy), 0);
    check_eq("resp_kept_on_send", 32'(resp), 32'hC0);

    // back-to-back responses while that frame is still going out
    rx_byte(8'hC0, 8'hC0);
    rx_byte(8'hBF, 8'hC0);
    rx_byte(8'hBE, 8'hBF);
    w = 0;
    while (!frm_snt && w < 1000) begin
      tick();
      w++;
    end
    check_eq("bg_frame_done", 32'(frm_snt), 1);
    repeat (20) tick();

    // reset during byte 2 of a frame
    cmd = 8'h01;
    data = 16'hA55A;
    send_cmd = 1'b1;
    tick();
    send_cmd = 1'b0;
    repeat (200) tick();
    rst = 1'b1;
    tick();
    check_eq("midrst_tx", 32'(TX), 1);
    check_eq("midrst_frm_snt", 32'(frm_snt), 0);
    check_eq("midrst_resp_rdy", 32'(resp_rdy), 0);
    check_eq("midrst_resp", 32'(resp), 0);
    rst = 1'b0;
    tick();
    send_frame(8'h03, 16'h0000, 8'h03, 8'h00, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
